msg_validity_checker: RTL and testbench

Parametrised checker for RC4 plaintext candidates. On `start` it streams a decrypted message out of the decrypted-message RAM, one address per cycle, and classifies each byte against a runtime-selectable character-class set. It stops at the first illegal byte and reports pass/fail, the failing index and the failing byte. It sits between the RC4 decrypt stage and the key-search controller, and replaces the fixed lowercase/space, fixed-length checker.

---
 rtl/rc4_check_pkg.sv | 32 +++
 rtl/char_class_match.sv | 24 ++
 rtl/msg_validity_checker.sv | 193 +++++++++++++++++++
 tb/tb_msg_validity_checker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_check_pkg.sv
// Shared definitions for the RC4 plaintext checking stages: FSM state
// encoding, ASCII class bounds and class-enable bit positions.
package rc4_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_LC_LO  = 8'd97;
    localparam logic [7:0] ASCII_LC_HI  = 8'd122;
    localparam logic [7:0] ASCII_SPACE  = 8'd32;
    localparam logic [7:0] ASCII_UC_LO  = 8'd65;
    localparam logic [7:0] ASCII_UC_HI  = 8'd90;
    localparam logic [7:0] ASCII_DIG_LO = 8'd48;
    localparam logic [7:0] ASCII_DIG_HI = 8'd57;

    localparam int CLS_LC    = 0;
    localparam int CLS_SPACE = 1;
    localparam int CLS_UC    = 2;
    localparam int CLS_DIG   = 3;

    // Inclusive range test on an unsigned byte.
    function automatic logic in_range(input logic [7:0] c,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/char_class_match.sv
// Combinational character classifier: a byte is legal when it falls in
// at least one of the enabled character classes.
module char_class_match
    import rc4_check_pkg::*;
(
    input  logic [7:0] data_byte,
    input  logic [3:0] class_en,
    output logic       legal
);

    // OR together every enabled class range.
    always_comb begin
        legal = 1'b0;
        if (class_en[CLS_LC] && in_range(data_byte, ASCII_LC_LO, ASCII_LC_HI))
            legal = 1'b1;
        if (class_en[CLS_SPACE] && (data_byte == ASCII_SPACE))
            legal = 1'b1;
        if (class_en[CLS_UC] && in_range(data_byte, ASCII_UC_LO, ASCII_UC_HI))
            legal = 1'b1;
        if (class_en[CLS_DIG] && in_range(data_byte, ASCII_DIG_LO, ASCII_DIG_HI))
            legal = 1'b1;
    end

endmodule

// File: rtl/msg_validity_checker.sv
// Streams a decrypted message out of RAM one address per cycle and checks
// each byte against a runtime-selected character-class set. Reports
// pass/fail plus the index and value of the first illegal byte.
module msg_validity_checker
    import rc4_check_pkg::*;
#(
    parameter int MSG_LEN     = 32,
    parameter int ADDR_W      = 5,
    parameter int RD_LATENCY  = 1,
    parameter int EARLY_ABORT = 1
)
(
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   check_len,
    input  logic [3:0]        class_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              key_valid,
    output logic [ADDR_W-1:0] bad_index,
    output logic [7:0]        bad_char
);

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(MSG_LEN);
    localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(MSG_LEN - 1);

    // Zero or oversize lengths fall back to the full message; store L-1.
    function automatic logic [ADDR_W-1:0] clamp_last(input logic [ADDR_W:0] len);
        if ((len == '0) || (len > LEN_MAX))
            return LAST_MAX;
        else
            return ADDR_W'(len - 1'b1);
    endfunction

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] last_idx;
    logic [3:0]        class_q;
    logic              fail;
    logic              accept;
    logic              legal;
    logic              rec_fail;
    logic              abort_now;
    logic              last_seen;
    logic              issue_vld;
    logic              vld_out;
    logic [ADDR_W-1:0] idx_out;

    assign accept    = (state == ST_IDLE) && start;
    assign rec_fail  = vld_out && !legal && !fail;
    assign abort_now = (EARLY_ABORT != 0) && rec_fail;
    assign last_seen = vld_out && (idx_out == last_idx);
    assign issue_vld = (state == ST_ISSUE) && !abort_now;

    char_class_match u_class (
        .data_byte (rd_data),
        .class_en  (class_q),
        .legal     (legal)
    );

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: issue L addresses, drain the read pipeline, pulse done.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (abort_now)
                    state_nxt = ST_DONE;
                else if (rd_addr == last_idx)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort_now || last_seen)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded status outputs.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Run configuration latched on an accepted start.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            last_idx <= '0;
            class_q  <= '0;
        end else if (accept) begin
            last_idx <= clamp_last(check_len);
            class_q  <= class_en;
        end
    end

    // Address counter: one address per ISSUE cycle, frozen on abort and at L-1.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            rd_addr <= '0;
        else if (accept)
            rd_addr <= '0;
        else if (issue_vld && (rd_addr != last_idx))
            rd_addr <= rd_addr + 1'b1;
    end

    // Tag pipeline matching the RAM read latency; an abort flushes every stage.
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              vld_p1, vld_p2;
            logic [ADDR_W-1:0] idx_p1, idx_p2;

            // Valid bits for the two in-flight read slots.
            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    vld_p1 <= 1'b0;
                    vld_p2 <= 1'b0;
                end else begin
                    vld_p1 <= issue_vld;
                    vld_p2 <= vld_p1 && !abort_now;
                end
            end

            // Index tags travel alongside their valid bits.
            always_ff @(posedge CLOCK_50) begin
                idx_p1 <= rd_addr;
                idx_p2 <= idx_p1;
            end

            assign vld_out = vld_p2;
            assign idx_out = idx_p2;
        end else begin : g_lat1
            logic              vld_p1;
            logic [ADDR_W-1:0] idx_p1;

            // Valid bit for the single in-flight read slot.
            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset)
                    vld_p1 <= 1'b0;
                else
                    vld_p1 <= issue_vld;
            end

            // Index tag travels alongside its valid bit.
            always_ff @(posedge CLOCK_50) begin
                idx_p1 <= rd_addr;
            end

            assign vld_out = vld_p1;
            assign idx_out = idx_p1;
        end
    endgenerate

    // First-failure capture and verdict, cleared on each accepted start.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fail      <= 1'b0;
            key_valid <= 1'b0;
            bad_index <= '0;
            bad_char  <= '0;
        end else if (accept) begin
            fail      <= 1'b0;
            key_valid <= 1'b0;
            bad_index <= '0;
            bad_char  <= '0;
        end else begin
            if (rec_fail) begin
                fail      <= 1'b1;
                bad_index <= idx_out;
                bad_char  <= rd_data;
            end
            if ((state != ST_DONE) && (state_nxt == ST_DONE))
                key_valid <= !(fail || rec_fail);
        end
    end

endmodule

// File: tb/tb_msg_validity_checker.sv
// Directed bench for msg_validity_checker: three instances cover
// RD_LATENCY=1/EARLY_ABORT=1, RD_LATENCY=1/EARLY_ABORT=0 and
// RD_LATENCY=2/EARLY_ABORT=1, each fed by its own RAM read model.
module tb_msg_validity_checker;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [5:0] check_len = '0;
    logic [3:0] class_en  = '0;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic [4:0] addr_a, addr_b, addr_c, bidx_a, bidx_b, bidx_c;
    logic [7:0] data_a, data_b, data_c, bch_a, bch_b, bch_c, q1_c;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic       kv_a, kv_b, kv_c;

    logic [7:0] mem [32];

    int checks   = 0;
    int failures = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    msg_validity_checker #(.MSG_LEN(32), .ADDR_W(5), .RD_LATENCY(1), .EARLY_ABORT(1)) dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start_a), .check_len(check_len),
        .class_en(class_en), .rd_addr(addr_a), .rd_data(data_a), .busy(busy_a),
        .done(done_a), .key_valid(kv_a), .bad_index(bidx_a), .bad_char(bch_a));

    msg_validity_checker #(.MSG_LEN(32), .ADDR_W(5), .RD_LATENCY(1), .EARLY_ABORT(0)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start_b), .check_len(check_len),
        .class_en(class_en), .rd_addr(addr_b), .rd_data(data_b), .busy(busy_b),
        .done(done_b), .key_valid(kv_b), .bad_index(bidx_b), .bad_char(bch_b));

    msg_validity_checker #(.MSG_LEN(32), .ADDR_W(5), .RD_LATENCY(2), .EARLY_ABORT(1)) dut_c (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start_c), .check_len(check_len),
        .class_en(class_en), .rd_addr(addr_c), .rd_data(data_c), .busy(busy_c),
        .done(done_c), .key_valid(kv_c), .bad_index(bidx_c), .bad_char(bch_c));

    // RAM read models: one- and two-cycle latency.
    always @(posedge CLOCK_50) begin
        data_a <= mem[addr_a];
        data_b <= mem[addr_b];
        q1_c   <= mem[addr_c];
        data_c <= q1_c;
    end

    // Output selection for the instance under test.
    int         sel = 0;
    logic       done_s, busy_s, kv_s;
    logic [4:0] addr_s, bidx_s;
    logic [7:0] bch_s;
    always_comb begin
        done_s = done_a; busy_s = busy_a; kv_s = kv_a;
        addr_s = addr_a; bidx_s = bidx_a; bch_s = bch_a;
        case (sel)
            1: begin
                done_s = done_b; busy_s = busy_b; kv_s = kv_b;
                addr_s = addr_b; bidx_s = bidx_b; bch_s = bch_b;
            end
            2: begin
                done_s = done_c; busy_s = busy_c; kv_s = kv_c;
                addr_s = addr_c; bidx_s = bidx_c; bch_s = bch_c;
            end
            default: ;
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        case (d)
            1: start_b = v;
            2: start_c = v;
            default: start_a = v;
        endcase
    endtask

    // "helloworld" padded with spaces, optionally with one byte overridden.
    task automatic load_msg(input int pos, input logic [7:0] v);
        string s;
        s = "helloworld";
        for (int i = 0; i < 32; i++)
            mem[i] = (i < 10) ? s[i] : 8'h20;
        if (pos >= 0)
            mem[pos] = v;
    endtask

    // Start a run on instance d and wait (bounded) for done.
    task automatic run(input int d, input logic [5:0] len, input logic [3:0] cls,
                       input int pulse_at, output int lat, output int maxa,
                       output int idle_ok, output int clear_ok, output int busy_ok);
        sel = d;
        lat = -1; maxa = 0; busy_ok = 1; clear_ok = 0;
        @(negedge CLOCK_50);
        idle_ok = (!done_s && !busy_s) ? 1 : 0;
        check_len = len;
        class_en  = cls;
        set_start(d, 1'b1);
        @(posedge CLOCK_50);
        #1 set_start(d, 1'b0);
        for (int n = 1; n <= 100; n++) begin
            @(negedge CLOCK_50);
            if (n == pulse_at) begin
                set_start(d, 1'b1);
                class_en  = 4'b0000;
                check_len = 6'd3;
            end else if (n == pulse_at + 1) begin
                set_start(d, 1'b0);
            end
            if (n == 1)
                clear_ok = (!kv_s && bidx_s == 0 && bch_s == 0) ? 1 : 0;
            if (!busy_s) busy_ok = 0;
            if (int'(addr_s) > maxa) maxa = int'(addr_s);
            if (done_s) begin
                lat = n;
                break;
            end
        end
    endtask

    typedef struct {
        int         d;
        logic [5:0] len;
        logic [3:0] cls;
        int         bpos;
        logic [7:0] bval;
        logic       kv;
        int         idx;
        logic [7:0] ch;
        int         lat;
        int         maxa;
    } vec_t;

    vec_t vt[24];

    initial begin
        int lat, maxa, idle_ok, clear_ok, busy_ok;
        string tag;

        vt[0]  = '{0, 6'd0,  4'b0011, -1, 8'h00, 1'b1, 0,  8'h00, 34, 31};
        vt[1]  = '{0, 6'd32, 4'b0011,  5, 8'h41, 1'b0, 5,  8'h41,  8,  6};
        vt[2]  = '{0, 6'd32, 4'b0111,  5, 8'h41, 1'b1, 0,  8'h00, 34, 31};
        vt[3]  = '{0, 6'd3,  4'b0011, 10, 8'h41, 1'b1, 0,  8'h00,  5,  2};
        vt[4]  = '{0, 6'd32, 4'b0000, -1, 8'h00, 1'b0, 0,  8'h68,  3,  1};
        vt[5]  = '{0, 6'd40, 4'b0011, 31, 8'h37, 1'b0, 31, 8'h37, 34, 31};
        vt[6]  = '{0, 6'd32, 4'b1011, 31, 8'h37, 1'b1, 0,  8'h00, 34, 31};
        vt[7]  = '{0, 6'd10, 4'b0001, -1, 8'h00, 1'b1, 0,  8'h00, 12,  9};
        vt[8]  = '{0, 6'd11, 4'b0001, -1, 8'h00, 1'b0, 10, 8'h20, 13, 10};
        vt[9]  = '{0, 6'd32, 4'b0010, -1, 8'h00, 1'b0, 0,  8'h68,  3,  1};
        vt[10] = '{0, 6'd32, 4'b1111,  0, 8'h7B, 1'b0, 0,  8'h7B,  3,  1};
        vt[11] = '{0, 6'd32, 4'b1111,  3, 8'h60, 1'b0, 3,  8'h60,  6,  4};
        vt[12] = '{0, 6'd32, 4'b0111,  7, 8'h40, 1'b0, 7,  8'h40, 10,  8};
        vt[13] = '{0, 6'd32, 4'b1111, 12, 8'h3A, 1'b0, 12, 8'h3A, 15, 13};
        vt[14] = '{0, 6'd32, 4'b1111,  2, 8'h5B, 1'b0, 2,  8'h5B,  5,  3};
        vt[15] = '{0, 6'd32, 4'b0111,  4, 8'h5A, 1'b1, 0,  8'h00, 34, 31};
        vt[16] = '{0, 6'd32, 4'b1011,  4, 8'h30, 1'b1, 0,  8'h00, 34, 31};
        vt[17] = '{0, 6'd32, 4'b1011,  4, 8'h39, 1'b1, 0,  8'h00, 34, 31};
        vt[18] = '{0, 6'd32, 4'b0011,  4, 8'h30, 1'b0, 4,  8'h30,  7,  5};
        vt[19] = '{1, 6'd32, 4'b0011,  5, 8'h41, 1'b0, 5,  8'h41, 34, 31};
        vt[20] = '{1, 6'd1,  4'b0011, -1, 8'h00, 1'b1, 0,  8'h00,  3,  0};
        vt[21] = '{2, 6'd0,  4'b0011, -1, 8'h00, 1'b1, 0,  8'h00, 35, 31};
        vt[22] = '{2, 6'd32, 4'b0011,  5, 8'h41, 1'b0, 5,  8'h41,  9,  7};
        vt[23] = '{2, 6'd2,  4'b0011, -1, 8'h00, 1'b1, 0,  8'h00,  5,  1};

        load_msg(-1, 8'h00);

        // Reset state of every instance.
        repeat (3) @(negedge CLOCK_50);
        chk("rst_a", {addr_a, busy_a, done_a, kv_a, bidx_a, bch_a}, 0);
        chk("rst_b", {addr_b, busy_b, done_b, kv_b, bidx_b, bch_b}, 0);
        chk("rst_c", {addr_c, busy_c, done_c, kv_c, bidx_c, bch_c}, 0);
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 24; i++) begin
            load_msg(vt[i].bpos, vt[i].bval);
            run(vt[i].d, vt[i].len, vt[i].cls, -1, lat, maxa, idle_ok, clear_ok, busy_ok);
            tag = $sformatf("v%0d", i);
            chk({tag, "_idle"},  idle_ok, 1);
            chk({tag, "_clear"}, clear_ok, 1);
            chk({tag, "_busy"},  busy_ok, 1);
            chk({tag, "_lat"},   lat, vt[i].lat);
            chk({tag, "_kv"},    int'(kv_s), int'(vt[i].kv));
            chk({tag, "_idx"},   int'(bidx_s), vt[i].idx);
            chk({tag, "_char"},  int'(bch_s), int'(vt[i].ch));
            chk({tag, "_maxa"},  maxa, vt[i].maxa);
        end

        // No early abort: two illegal bytes, the first one is reported.
        load_msg(2, 8'h41);
        mem[9] = 8'h42;
        run(1, 6'd32, 4'b0011, -1, lat, maxa, idle_ok, clear_ok, busy_ok);
        chk("ea0_lat", lat, 34);
        chk("ea0_kv", int'(kv_s), 0);
        chk("ea0_idx", int'(bidx_s), 2);
        chk("ea0_char", int'(bch_s), 8'h41);

        // Latency 2, back-to-back, with a start pulse and input changes mid-run.
        load_msg(-1, 8'h00);
        run(2, 6'd0, 4'b0011, 10, lat, maxa, idle_ok, clear_ok, busy_ok);
        chk("b2b1_lat", lat, 35);
        chk("b2b1_kv", int'(kv_s), 1);
        chk("b2b1_maxa", maxa, 31);
        run(2, 6'd0, 4'b0011, -1, lat, maxa, idle_ok, clear_ok, busy_ok);
        chk("b2b2_idle", idle_ok, 1);
        chk("b2b2_lat", lat, 35);
        chk("b2b2_kv", int'(kv_s), 1);

        // Reset four cycles into a run that has already recorded a failure.
        sel = 1;
        load_msg(1, 8'h41);
        @(negedge CLOCK_50);
        check_len = 6'd0;
        class_en  = 4'b0011;
        start_b   = 1'b1;
        @(posedge CLOCK_50);
        #1 start_b = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        chk("pre_rst_idx", int'(bidx_b), 1);
        chk("pre_rst_addr", int'(addr_b), 3);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("mid_rst_b", {addr_b, busy_b, done_b, kv_b, bidx_b, bch_b}, 0);
        reset = 1'b0;
        load_msg(-1, 8'h00);
        run(1, 6'd0, 4'b0011, -1, lat, maxa, idle_ok, clear_ok, busy_ok);
        chk("post_rst_lat", lat, 34);
        chk("post_rst_kv", int'(kv_s), 1);
        chk("post_rst_idx", int'(bidx_s), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
